// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared types and default widths for the pipeline stage registers
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  localparam int CTRL_W_WB   = 2;
  localparam int CTRL_W_MEM  = 4;
  localparam int PIPE_RD_W   = 5;
  localparam int PIPE_DATA_W = 32;

  function automatic logic [1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_entry.sv
// ============================================================================
// pipe_entry : one valid bit plus payload register with load and clear enables
// Revision   : 1.0
// ============================================================================
`default_nettype none

module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Clearing only drops the valid bit; the payload keeps its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// pipe_stage_reg : handshaked pipeline boundary register with optional skid
// Revision       : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = 2,
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 2,
  parameter int RD_W     = 5,
  parameter int SKID     = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]            in_rd,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [RD_W-1:0]            out_rd,
  output logic [1:0]                 occupancy
);

  localparam int PAY_W = CTRL_W + NUM_DATA*DATA_W + RD_W;

  if (NUM_DATA < 1) begin : g_num_data_chk
    $error("pipe_stage_reg: NUM_DATA must be at least 1");
  end

  logic             w_rdy_eff;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_m_valid;
  logic             w_s_valid;
  logic [PAY_W-1:0] w_in_pay;
  logic [PAY_W-1:0] w_m_pay;
  logic [PAY_W-1:0] w_s_pay;
  logic [PAY_W-1:0] w_m_din;
  logic             w_m_load;
  logic             w_m_clear;
  logic             w_s_load;
  logic             w_s_clear;
  logic [CTRL_W-1:0] w_m_ctrl;
  stage_state_t     w_state_nxt;
  stage_state_t     r_state;
  logic             r_in_ready;

  assign w_rdy_eff  = out_ready & ~stall;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = w_m_valid & w_rdy_eff;
  assign w_in_pay   = {in_ctrl, in_data, in_rd};

  // With SKID=0 in_ready already implies an output transfer whenever M is
  // occupied, so the "input only" arc out of ONE is never taken.
  always_comb begin
    w_state_nxt = r_state;
    w_m_load    = 1'b0;
    w_m_clear   = 1'b0;
    w_s_load    = 1'b0;
    w_s_clear   = 1'b0;
    w_m_din     = w_in_pay;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_m_clear   = 1'b1;
      w_s_clear   = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_m_load    = 1'b1;
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_m_load = 1'b1;
          end else if (w_out_xfer) begin
            w_m_clear   = 1'b1;
            w_state_nxt = EMPTY;
          end else if (w_in_xfer) begin
            w_s_load    = 1'b1;
            w_state_nxt = TWO;
          end
        end
        TWO: begin
          if (w_out_xfer) begin
            w_m_load    = 1'b1;
            w_m_din     = w_s_pay;
            w_s_clear   = 1'b1;
            w_state_nxt = ONE;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_m_clear   = 1'b1;
          w_s_clear   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != TWO);
    end
  end

  assign in_ready = (SKID != 0) ? r_in_ready : (~w_m_valid | w_rdy_eff);

  pipe_entry #(.W(PAY_W)) u_m (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_m_load),
    .i_clear (w_m_clear),
    .i_data  (w_m_din),
    .o_valid (w_m_valid),
    .o_data  (w_m_pay)
  );

  if (SKID != 0) begin : g_skid
    pipe_entry #(.W(PAY_W)) u_s (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_s_load),
      .i_clear (w_s_clear),
      .i_data  (w_in_pay),
      .o_valid (w_s_valid),
      .o_data  (w_s_pay)
    );
  end else begin : g_no_skid
    assign w_s_valid = 1'b0;
    assign w_s_pay   = '0;
  end

  assign {w_m_ctrl, out_data, out_rd} = w_m_pay;

  // Bubbles must never carry RegWrite/MemToReg downstream.
  assign out_valid = w_m_valid;
  assign out_ctrl  = w_m_valid ? w_m_ctrl : '0;
  assign occupancy = occ_count(w_m_valid, w_s_valid);

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// tb_pipe_stage_reg : scoreboard bench driving SKID=1 and SKID=0 instances
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [63:0] data;
    logic [4:0]  rd;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_ctrl = '0;
  logic [63:0] in_data = '0;
  logic [4:0]  in_rd = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        s1_ir, s1_ov, s0_ir, s0_ov;
  logic [1:0]  s1_oc, s0_oc, s1_occ, s0_occ;
  logic [63:0] s1_od, s0_od;
  logic [4:0]  s1_ord, s0_ord;

  int n_vec  = 0;
  int n_fail = 0;

  // Per-instance expected contents: circular FIFO, index 1 = SKID=1 instance.
  item_t      sbm [0:1][0:1023];
  logic [9:0] head [0:1];
  logic [9:0] tail [0:1];
  logic       after_rst [0:1];

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(2), .DATA_W(32), .NUM_DATA(2), .RD_W(5), .SKID(1)) u_skid (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s1_ir),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd),
    .stall(stall), .flush(flush), .out_valid(s1_ov), .out_ready(out_ready),
    .out_ctrl(s1_oc), .out_data(s1_od), .out_rd(s1_ord), .occupancy(s1_occ)
  );

  pipe_stage_reg #(.CTRL_W(2), .DATA_W(32), .NUM_DATA(2), .RD_W(5), .SKID(0)) u_noskid (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s0_ir),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd),
    .stall(stall), .flush(flush), .out_valid(s0_ov), .out_ready(out_ready),
    .out_ctrl(s0_oc), .out_data(s0_od), .out_rd(s0_ord), .occupancy(s0_occ)
  );

  task automatic chk(input string name, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (skid=%0d) t=%0t got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  initial begin
    head[0] = '0; head[1] = '0; tail[0] = '0; tail[1] = '0;
    after_rst[0] = 1'b0; after_rst[1] = 1'b0;
  end

  // Stimulus side: an accepted input is the next item owed by that instance.
  always @(posedge clk) begin
    if (!reset && !flush && in_valid) begin
      if (s0_ir) begin
        sbm[0][tail[0]] = '{ctrl: in_ctrl, data: in_data, rd: in_rd};
        tail[0] = tail[0] + 10'd1;
      end
      if (s1_ir) begin
        sbm[1][tail[1]] = '{ctrl: in_ctrl, data: in_data, rd: in_rd};
        tail[1] = tail[1] + 10'd1;
      end
    end
  end

  // Monitor side: compare the presented output, then retire or discard.
  always @(negedge clk) begin : monitor
    logic        v, ir;
    logic [1:0]  oc, occ;
    logic [63:0] od;
    logic [4:0]  ord;
    logic [9:0]  sz;
    logic        exp_ir;
    item_t       e;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        v = s1_ov; ir = s1_ir; oc = s1_oc; occ = s1_occ; od = s1_od; ord = s1_ord;
      end else begin
        v = s0_ov; ir = s0_ir; oc = s0_oc; occ = s0_occ; od = s0_od; ord = s0_ord;
      end
      if (reset) begin
        head[k] = tail[k];
        after_rst[k] = 1'b1;
      end else begin
        if (after_rst[k]) begin
          chk("reset_data", k, od, 64'd0);
          chk("reset_rd", k, {59'd0, ord}, 64'd0);
          after_rst[k] = 1'b0;
        end
        sz = tail[k] - head[k];
        exp_ir = (k == 1) ? (sz < 10'd2) : ((sz == 10'd0) || (out_ready && !stall));
        chk("out_valid", k, {63'd0, v}, {63'd0, (sz != 10'd0)});
        chk("occupancy", k, {62'd0, occ}, {54'd0, sz});
        chk("in_ready", k, {63'd0, ir}, {63'd0, exp_ir});
        if (sz != 10'd0) begin
          e = sbm[k][head[k]];
          chk("out_ctrl", k, {62'd0, oc}, {62'd0, e.ctrl});
          chk("out_data", k, od, e.data);
          chk("out_rd", k, {59'd0, ord}, {59'd0, e.rd});
        end else begin
          chk("bubble_ctrl", k, {62'd0, oc}, 64'd0);
        end
        if (flush) head[k] = tail[k];
        else if (sz != 10'd0 && out_ready && !stall) head[k] = head[k] + 10'd1;
      end
    end
  end

  function automatic item_t rnd_item();
    item_t      it;
    logic [31:0] r;
    r = $urandom;
    it.ctrl = r[1:0];
    it.rd   = r[6:2];
    it.data = {$urandom, $urandom};
    return it;
  endfunction

  task automatic cyc(input logic v, input logic ordy, input logic st, input logic fl,
                     input item_t it);
    in_valid  = v;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    in_ctrl   = it.ctrl;
    in_data   = it.data;
    in_rd     = it.rd;
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    item_t a, b, c, first;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Streaming
    first = '{ctrl: 2'b11, data: {32'hDEAD_BEEF, 32'h0000_0010}, rd: 5'd9};
    cyc(1'b1, 1'b1, 1'b0, 1'b0, first);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, rnd_item());
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Skid fill: A held, B offered with downstream blocked
    a = rnd_item(); b = rnd_item();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, a);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, b);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Stall behaves like out_ready=0
    a = rnd_item(); a.rd = 5'd9;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, a);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Flush in TWO with C offered
    a = rnd_item(); b = rnd_item(); c = rnd_item();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, a);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, b);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, c);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Randomised traffic with occasional flush and mid-run reset
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] r;
      r = $urandom;
      reset = ($urandom_range(0, 499) == 0);
      cyc(r[0], r[1], r[2], (r[11:5] == 7'd0), rnd_item());
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
